gpr_wb_arbiter: RTL and testbench

- Shares the single general-purpose register write port (index, data, enable, half-word scope) between two writeback sources: execute-stage results (EX) and memory-load results (MEM).
- Each source has a valid/ready handshake and a 1-entry holding buffer.
- Buffered writes are arbitrated round-robin, with an age override that preserves program order for same-register writes.
- Exports a pending-write busy map so the issue stage can stall on RAW hazards against buffered writes.

---
 rtl/gpr_pkg.sv | 15 +
 rtl/gpr_wb_slot.sv | 39 +++
 rtl/gpr_wb_arbiter.sv | 68 ++++++
 tb/tb_gpr_wb_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared GPR writeback constants, scope encodings and write-request type
package gpr_pkg;
  localparam int GPR_IDX_W = 4;
  localparam int GPR_NUM = 16;
  localparam int GPR_DW = 32;
  localparam logic [1:0] WS_NONE = 2'b00;
  localparam logic [1:0] WS_LO = 2'b01;
  localparam logic [1:0] WS_HI = 2'b10;
  localparam logic [1:0] WS_ALL = 2'b11;
  typedef struct packed {
    logic [GPR_IDX_W-1:0] idx;
    logic [GPR_DW-1:0] data;
    logic [1:0] scope;
  } wb_req_t;
endpackage

// File: rtl/gpr_wb_slot.sv
// gpr_wb_slot: 1-entry writeback buffer with valid/ready handshake (ports: request in, grant in, buffered entry out, capture strobe out)
module gpr_wb_slot
  import gpr_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [GPR_IDX_W-1:0] idx_i,
  input  logic [DW-1:0]        data_i,
  input  logic [1:0]           scope_i,
  input  logic                 grant_i,
  output logic                 ready_o,
  output logic                 capture_o,
  output logic                 valid_o,
  output logic [GPR_IDX_W-1:0] idx_o,
  output logic [DW-1:0]        data_o,
  output logic [1:0]           scope_o
);
  assign ready_o = !valid_o || grant_i;
  // scope-none requests complete the handshake but never occupy the buffer
  assign capture_o = valid_i && ready_o && (scope_i != WS_NONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      idx_o <= '0;
      data_o <= '0;
      scope_o <= WS_NONE;
    end else if (capture_o) begin
      valid_o <= 1'b1;
      idx_o <= idx_i;
      data_o <= data_i;
      scope_o <= scope_i;
    end else if (grant_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the GPR write port between EX and MEM writeback buffers (handshakes in, GPR write port, busy map and grant strobes out)
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [GPR_IDX_W-1:0] ex_idx_i,
  input  logic [DW-1:0]        ex_data_i,
  input  logic [1:0]           ex_scope_i,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [GPR_IDX_W-1:0] mem_idx_i,
  input  logic [DW-1:0]        mem_data_i,
  input  logic [1:0]           mem_scope_i,
  output logic [GPR_IDX_W-1:0] reg_w_idx_o,
  output logic [DW-1:0]        wdata_o,
  output logic                 wen_o,
  output logic [1:0]           wr_scope_o,
  output logic [NREGS-1:0]     busy_o,
  output logic                 ex_grant_o,
  output logic                 mem_grant_o
);
  logic ev, mv, ex_cap, mem_cap, rr_mem, mem_older;
  logic [GPR_IDX_W-1:0] eidx, midx;
  logic [DW-1:0] edata, mdata;
  logic [1:0] escope, mscope;
  gpr_wb_slot #(.DW(DW)) u_ex (
    .clk(clk), .rst_n(rst_n), .valid_i(ex_valid_i), .idx_i(ex_idx_i), .data_i(ex_data_i),
    .scope_i(ex_scope_i), .grant_i(ex_grant_o), .ready_o(ex_ready_o), .capture_o(ex_cap),
    .valid_o(ev), .idx_o(eidx), .data_o(edata), .scope_o(escope)
  );
  gpr_wb_slot #(.DW(DW)) u_mem (
    .clk(clk), .rst_n(rst_n), .valid_i(mem_valid_i), .idx_i(mem_idx_i), .data_i(mem_data_i),
    .scope_i(mem_scope_i), .grant_i(mem_grant_o), .ready_o(mem_ready_o), .capture_o(mem_cap),
    .valid_o(mv), .idx_o(midx), .data_o(mdata), .scope_o(mscope)
  );
  // same-register writes keep program order; otherwise round-robin
  assign ex_grant_o = ev && (!mv || ((eidx == midx) ? !mem_older : !rr_mem));
  assign mem_grant_o = mv && !ex_grant_o;
  assign wen_o = ex_grant_o || mem_grant_o;
  assign reg_w_idx_o = ex_grant_o ? eidx : mem_grant_o ? midx : '0;
  assign wdata_o = ex_grant_o ? edata : mem_grant_o ? mdata : '0;
  assign wr_scope_o = ex_grant_o ? escope : mem_grant_o ? mscope : WS_NONE;
  always_comb begin
    busy_o = '0;
    if (ev) busy_o[eidx] = 1'b1;
    if (mv) busy_o[midx] = 1'b1;
  end
  // age is only meaningful while both buffers stay occupied; a lone capture
  // is younger than the survivor, simultaneous capture counts EX as older
  logic ev_n, mv_n;
  assign ev_n = ex_cap || (ev && !ex_grant_o);
  assign mv_n = mem_cap || (mv && !mem_grant_o);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_mem <= 1'b0;
      mem_older <= 1'b0;
    end else begin
      rr_mem <= ex_grant_o ? 1'b1 : mem_grant_o ? 1'b0 : rr_mem;
      mem_older <= !(ev_n && mv_n) ? 1'b0 : (ex_cap && !mem_cap) ? 1'b1 : mem_cap ? 1'b0 : mem_older;
    end
  end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;
  import gpr_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid, ex_ready_o, mem_valid, mem_ready_o, wen_o, ex_grant_o, mem_grant_o;
  logic [3:0] ex_idx, mem_idx, reg_w_idx_o;
  logic [31:0] ex_data, mem_data, wdata_o;
  logic [1:0] ex_scope, mem_scope, wr_scope_o;
  logic [15:0] busy_o;
  int tests = 0, fails = 0;
  logic [3:0] log_idx[$];
  logic [31:0] log_data[$];
  gpr_wb_arbiter #(.NREGS(16), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready_o), .ex_idx_i(ex_idx), .ex_data_i(ex_data), .ex_scope_i(ex_scope),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready_o), .mem_idx_i(mem_idx), .mem_data_i(mem_data), .mem_scope_i(mem_scope),
    .reg_w_idx_o(reg_w_idx_o), .wdata_o(wdata_o), .wen_o(wen_o), .wr_scope_o(wr_scope_o),
    .busy_o(busy_o), .ex_grant_o(ex_grant_o), .mem_grant_o(mem_grant_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && wen_o) begin
    log_idx.push_back(reg_w_idx_o);
    log_data.push_back(wdata_o);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ex_valid = 0; ex_idx = 0; ex_data = 0; ex_scope = WS_NONE;
    mem_valid = 0; mem_idx = 0; mem_data = 0; mem_scope = WS_NONE;
  endtask
  task automatic test_reset();
    rst_n = 0; idle(); step(); step();
    tests++; if ({wen_o, ex_grant_o, mem_grant_o} !== 3'b000) begin fails++; $display("FAIL reset_wen_grants: got %b want 000", {wen_o, ex_grant_o, mem_grant_o}); end
    tests++; if ({reg_w_idx_o, wdata_o, wr_scope_o} !== 38'd0) begin fails++; $display("FAIL reset_port: got %h want 0", {reg_w_idx_o, wdata_o, wr_scope_o}); end
    tests++; if (busy_o !== 16'h0) begin fails++; $display("FAIL reset_busy: got %h want 0000", busy_o); end
    tests++; if ({ex_ready_o, mem_ready_o} !== 2'b11) begin fails++; $display("FAIL reset_ready: got %b want 11", {ex_ready_o, mem_ready_o}); end
    rst_n = 1; step();
  endtask
  task automatic test_single();
    ex_valid = 1; ex_idx = 3; ex_data = 32'h12345678; ex_scope = WS_ALL;
    step(); ex_valid = 0;
    tests++; if ({wen_o, ex_grant_o, reg_w_idx_o} !== {2'b11, 4'd3}) begin fails++; $display("FAIL single_wen_idx: got %b/%b/%0d want 1/1/3", wen_o, ex_grant_o, reg_w_idx_o); end
    tests++; if ({wdata_o, wr_scope_o} !== {32'h12345678, 2'b11}) begin fails++; $display("FAIL single_data: got %h/%b want 12345678/11", wdata_o, wr_scope_o); end
    tests++; if (busy_o !== 16'h0008) begin fails++; $display("FAIL single_busy: got %h want 0008", busy_o); end
    step();
    tests++; if ({wen_o, busy_o} !== 17'd0) begin fails++; $display("FAIL single_done: got wen=%b busy=%h want 0/0000", wen_o, busy_o); end
  endtask
  task automatic test_age_same_edge();
    ex_valid = 1; ex_idx = 6; ex_data = 32'hA; ex_scope = WS_ALL;
    mem_valid = 1; mem_idx = 6; mem_data = 32'hB; mem_scope = WS_ALL;
    step(); idle();
    tests++; if ({ex_grant_o, mem_grant_o, wdata_o} !== {2'b10, 32'hA}) begin fails++; $display("FAIL age_first: got %b%b/%h want 10/0000000a", ex_grant_o, mem_grant_o, wdata_o); end
    tests++; if (busy_o !== 16'h0040) begin fails++; $display("FAIL age_busy: got %h want 0040", busy_o); end
    step();
    tests++; if ({ex_grant_o, mem_grant_o, wdata_o} !== {2'b01, 32'hB}) begin fails++; $display("FAIL age_second: got %b%b/%h want 01/0000000b", ex_grant_o, mem_grant_o, wdata_o); end
    tests++; if (busy_o !== 16'h0040) begin fails++; $display("FAIL age_busy_hold: got %h want 0040", busy_o); end
    step();
    tests++; if (busy_o !== 16'h0) begin fails++; $display("FAIL age_busy_clear: got %h want 0000", busy_o); end
  endtask
  task automatic test_mem_then_ex();
    int base = log_idx.size();
    mem_valid = 1; mem_idx = 5; mem_data = 32'hAAAA; mem_scope = WS_ALL;
    step(); mem_valid = 0;
    ex_valid = 1; ex_idx = 5; ex_data = 32'hBBBB; ex_scope = WS_ALL;
    tests++; if ({mem_grant_o, ex_ready_o, wdata_o} !== {2'b11, 32'hAAAA}) begin fails++; $display("FAIL order_mem: got %b%b/%h want 11/0000aaaa", mem_grant_o, ex_ready_o, wdata_o); end
    step(); ex_valid = 0;
    tests++; if ({ex_grant_o, wdata_o} !== {1'b1, 32'hBBBB}) begin fails++; $display("FAIL order_ex: got %b/%h want 1/0000bbbb", ex_grant_o, wdata_o); end
    step();
    tests++; if (log_idx.size() - base != 2 || log_data[log_data.size()-1] !== 32'hBBBB || log_data[log_data.size()-2] !== 32'hAAAA)
      begin fails++; $display("FAIL order_commit: got %0d writes want 2 ending aaaa,bbbb", log_idx.size() - base); end
  endtask
  task automatic test_scope();
    mem_valid = 1; mem_idx = 7; mem_data = 32'h0000BEEF; mem_scope = WS_HI;
    step(); mem_valid = 0;
    tests++; if ({mem_grant_o, wr_scope_o, wdata_o, reg_w_idx_o} !== {1'b1, 2'b10, 32'h0000BEEF, 4'd7}) begin fails++; $display("FAIL scope_hi: got %b/%b/%h/%0d want 1/10/0000beef/7", mem_grant_o, wr_scope_o, wdata_o, reg_w_idx_o); end
    step();
    mem_valid = 1; mem_idx = 8; mem_data = 32'h5; mem_scope = WS_NONE;
    tests++; if (mem_ready_o !== 1'b1) begin fails++; $display("FAIL scope_none_ready: got %b want 1", mem_ready_o); end
    step(); mem_valid = 0;
    tests++; if ({wen_o, busy_o} !== 17'd0) begin fails++; $display("FAIL scope_none_drop: got wen=%b busy=%h want 0/0000", wen_o, busy_o); end
    step();
    tests++; if (wen_o !== 1'b0) begin fails++; $display("FAIL scope_none_late: got %b want 0", wen_o); end
  endtask
  task automatic test_reset_mid();
    int base = log_idx.size();
    int bad = 0;
    ex_valid = 1; ex_idx = 4; ex_data = 32'h44; ex_scope = WS_ALL;
    mem_valid = 1; mem_idx = 9; mem_data = 32'h99; mem_scope = WS_ALL;
    step(); idle();
    tests++; if ({wen_o, busy_o} !== {1'b1, 16'h0210}) begin fails++; $display("FAIL rstmid_full: got wen=%b busy=%h want 1/0210", wen_o, busy_o); end
    #1 rst_n = 0;
    #1;
    tests++; if ({wen_o, busy_o} !== 17'd0) begin fails++; $display("FAIL rstmid_async: got wen=%b busy=%h want 0/0000", wen_o, busy_o); end
    @(posedge clk); #1 rst_n = 1;
    step(); step(); step();
    for (int i = base; i < log_idx.size(); i++) if (log_idx[i] == 4 || log_idx[i] == 9) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_dropped: got %0d stale writes want 0", bad); end
  endtask
  task automatic test_back_to_back();
    int base = log_idx.size();
    int es = 0, ms = 0, viol = 0, ne = 0, nm = 0, bad = 0, alt = 0;
    logic ae, am;
    for (int c = 0; c < 20; c++) begin
      ex_valid = (es < 6); ex_idx = 1; ex_data = 32'h100 + es; ex_scope = WS_ALL;
      mem_valid = (ms < 6); mem_idx = 2; mem_data = 32'h200 + ms; mem_scope = WS_ALL;
      if (!(ex_ready_o || mem_ready_o)) viol++;
      ae = ex_valid && ex_ready_o;
      am = mem_valid && mem_ready_o;
      step();
      es += int'(ae); ms += int'(am);
    end
    idle(); step();
    for (int i = base; i < log_idx.size(); i++) begin
      if (log_idx[i] == 1) begin if (log_data[i] !== 32'h100 + ne) bad++; ne++; end
      else if (log_idx[i] == 2) begin if (log_data[i] !== 32'h200 + nm) bad++; nm++; end
      else bad++;
      if (i > base && log_idx[i] == log_idx[i-1]) alt++;
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL b2b_ready: got %0d cycles with no ready want 0", viol); end
    tests++; if (es != 6 || ms != 6) begin fails++; $display("FAIL b2b_accept: got %0d/%0d want 6/6", es, ms); end
    tests++; if (ne != 6 || nm != 6) begin fails++; $display("FAIL b2b_writes: got %0d/%0d want 6/6", ne, nm); end
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_data: got %0d bad writes want 0", bad); end
    tests++; if (alt != 0) begin fails++; $display("FAIL b2b_alternate: got %0d repeats want 0", alt); end
  endtask
  task automatic test_starvation();
    int last_e = -1, last_m = -1, gap_e = 0, gap_m = 0, n = 0;
    for (int c = 0; c < 12; c++) begin
      ex_valid = (c < 10); ex_idx = 1; ex_data = 32'h300 + c; ex_scope = WS_ALL;
      mem_valid = 1; mem_idx = 2; mem_data = 32'h400 + c; mem_scope = WS_ALL;
      step();
      if (ex_grant_o) begin if (last_e >= 0 && c - last_e > gap_e) gap_e = c - last_e; last_e = c; n++; end
      if (mem_grant_o) begin if (last_m >= 0 && c - last_m > gap_m) gap_m = c - last_m; last_m = c; end
    end
    idle(); step(); step();
    tests++; if (n < 5 || gap_e > 2) begin fails++; $display("FAIL starve_ex: got %0d grants max gap %0d want >=5 gap<=2", n, gap_e); end
    tests++; if (gap_m > 2 || gap_m == 0) begin fails++; $display("FAIL starve_mem: got max gap %0d want 1..2", gap_m); end
  endtask
  initial begin
    idle();
    test_reset();
    test_single();
    test_age_same_edge();
    test_mem_then_ex();
    test_scope();
    test_reset_mid();
    test_back_to_back();
    test_starvation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
